// File: rtl/hpm_counter_bank_pkg.sv
// hpm_counter_bank_pkg: CSR addresses and constants shared by the HPM counter bank
package hpm_counter_bank_pkg;
  typedef enum logic [11:0] {
    MCOUNTINHIBIT = 12'h320
  } CSRs_;
  localparam int HPM_FIRST_INDEX = 3;
  localparam logic [11:0] HPM_COUNTER_BASE = 12'hB00;
  localparam logic [11:0] HPM_COUNTERH_BASE = 12'hB80;
  localparam logic [11:0] HPM_EVENT_BASE = 12'h320;
endpackage

// File: rtl/hpm_counter_slice.sv
// hpm_counter_slice: one mhpmcounter with its event selector, write priority and wrap pulse
module hpm_counter_slice
  import hpm_counter_bank_pkg::*;
#(
  parameter int NUM_EVENTS = 8,
  parameter int COUNTER_WIDTH = 64,
  parameter int SEL_W = $clog2(NUM_EVENTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lo_wr,
  input  logic                     hi_wr,
  input  logic                     sel_wr,
  input  logic                     inhibit,
  input  logic [31:0]              wdata,
  input  logic [NUM_EVENTS-1:0]    events_q,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic [SEL_W-1:0]         sel,
  output logic                     overflow
);
  logic [NUM_EVENTS:0] ev_ext;
  logic hit;
  logic wr;
  logic sel_legal;
  // selector 0 lands on the constant-zero bit, so "no event" needs no special case
  assign ev_ext = {events_q, 1'b0};
  assign hit = ev_ext[sel] && !inhibit;
  assign wr = lo_wr || hi_wr;
  assign sel_legal = wdata != 32'd0 && wdata <= 32'(NUM_EVENTS);
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      sel <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= hit && !wr && &count;
      if (sel_wr) sel <= sel_legal ? wdata[SEL_W-1:0] : '0;
      if (lo_wr) count[31:0] <= wdata;
      else if (hi_wr) count[COUNTER_WIDTH-1:32] <= wdata[COUNTER_WIDTH-33:0];
      else if (hit) count <= count + COUNTER_WIDTH'(1);
    end
  end
endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: mhpmcounter/mhpmevent/mcountinhibit bank beside the core CSR file
module hpm_counter_bank
  import hpm_counter_bank_pkg::*;
#(
  parameter int NUM_COUNTERS = 4,
  parameter int NUM_EVENTS = 8,
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [11:0]             csrAddress,
  input  logic                    csrWriteEnable,
  input  logic [31:0]             csrWriteData,
  input  logic [NUM_EVENTS-1:0]   events,
  output logic                    csrHit,
  output logic [31:0]             csrReadData,
  output logic [NUM_COUNTERS-1:0] overflowPulse
);
  localparam int SEL_W = $clog2(NUM_EVENTS + 1);
  logic [4:0] idx;
  logic in_range;
  logic lo_hit;
  logic hi_hit;
  logic ev_hit;
  logic inh_hit;
  logic [NUM_EVENTS-1:0] event_q;
  logic [NUM_COUNTERS-1:0] inhibit;
  logic [COUNTER_WIDTH-1:0] counts [NUM_COUNTERS];
  logic [SEL_W-1:0] sels [NUM_COUNTERS];
  logic [63:0] cnt_rd;
  logic [SEL_W-1:0] sel_rd;
  assign idx = csrAddress[4:0];
  assign in_range = idx >= 5'(HPM_FIRST_INDEX);
  assign lo_hit = csrAddress[11:5] == HPM_COUNTER_BASE[11:5] && in_range;
  assign hi_hit = csrAddress[11:5] == HPM_COUNTERH_BASE[11:5] && in_range;
  assign ev_hit = csrAddress[11:5] == HPM_EVENT_BASE[11:5] && in_range;
  assign inh_hit = csrAddress == MCOUNTINHIBIT;
  assign csrHit = lo_hit || hi_hit || ev_hit || inh_hit;
  always_ff @(posedge clock) begin
    if (reset) begin
      event_q <= '0;
      inhibit <= '0;
    end else begin
      event_q <= events;
      if (csrWriteEnable && inh_hit) inhibit <= csrWriteData[HPM_FIRST_INDEX +: NUM_COUNTERS];
    end
  end
  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
    logic sel_me;
    assign sel_me = csrWriteEnable && idx == 5'(i + HPM_FIRST_INDEX);
    hpm_counter_slice #(
      .NUM_EVENTS(NUM_EVENTS),
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .SEL_W(SEL_W)
    ) u_slice (
      .clk(clock),
      .rst(reset),
      .lo_wr(sel_me && lo_hit),
      .hi_wr(sel_me && hi_hit),
      .sel_wr(sel_me && ev_hit),
      .inhibit(inhibit[i]),
      .wdata(csrWriteData),
      .events_q(event_q),
      .count(counts[i]),
      .sel(sels[i]),
      .overflow(overflowPulse[i])
    );
  end
  // unimplemented indices match no slice and fall through as zero
  always_comb begin
    cnt_rd = '0;
    sel_rd = '0;
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      if (idx == 5'(n + HPM_FIRST_INDEX)) begin
        cnt_rd = 64'(counts[n]);
        sel_rd = sels[n];
      end
    end
    csrReadData = lo_hit ? cnt_rd[31:0] :
                  hi_hit ? cnt_rd[63:32] :
                  ev_hit ? 32'(sel_rd) :
                  inh_hit ? 32'({inhibit, 3'b000}) : 32'd0;
  end
endmodule

// File: doc/hpm_counter_bank.md
Name: hpm_counter_bank

Overview:
Parametrised bank of RISC-V machine hardware performance monitor counters. It replaces the current read-only-zero handling of mhpmcounterN, mhpmcounterNh and mhpmeventN, and adds mcountinhibit for those counters.
- Sits beside the core CSR file.
- The CSR file forwards the address, write strobe and write data, and muxes in csrReadData when csrHit is asserted.
- Microarchitectural event strobes from the pipeline drive the counters through one register stage.

Parameters:
NUM_COUNTERS, 4, implemented counters mhpmcounter3..mhpmcounter(3+NUM_COUNTERS-1); legal range 1..29
NUM_EVENTS, 8, width of the events input; legal event selector values are 1..NUM_EVENTS
COUNTER_WIDTH, 64, implemented counter bits; legal range 33..64

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
csrAddress  in  12  CSR address of the current access
csrWriteEnable  in  1  commit a write to csrAddress this cycle
csrWriteData  in  32  final write value; the CSR file has already resolved CSRRS/CSRRC
events  in  NUM_EVENTS  one-cycle event strobes; several may be high in the same cycle
csrHit  out  1  csrAddress is handled by this block
csrReadData  out  32  read value for csrAddress
overflowPulse  out  NUM_COUNTERS  one-cycle pulse when a counter wraps to zero

Behaviour:
- Reset (synchronous, active-high), applies even mid-operation:
  - All counters, event selectors, inhibit bits, the event register and overflowPulse clear to 0.
  - csrReadData therefore reads 0 for every handled CSR in the cycle after reset.
- csrHit and csrReadData are combinational from csrAddress and the current register state.
- csrHit is 1 for these ranges, implemented or not:
  - 0xB03–0xB1F and 0xB83–0xB9F (counter low/high halves)
  - 0x323–0x33F (event selectors)
  - 0x320 (mcountinhibit)
- Unimplemented counter indices (n ≥ 3+NUM_COUNTERS):
  - Read 0 and ignore writes.
  - csrHit remains 1.
- Counter read/write:
  - The low half maps to counter bits 31:0.
  - The high half maps to bits COUNTER_WIDTH-1:32, zero-extended on read.
  - A write replaces only the addressed half.
- Read during write returns the old value; the new value is visible the next cycle.
- Event selector field:
  - Stored width is clog2(NUM_EVENTS+1) bits; reads are zero-extended.
  - Writes are WARL: a value of 0 or greater than NUM_EVENTS is stored as 0 (no event).
- mcountinhibit:
  - Bits 3..3+NUM_COUNTERS-1 are writable.
  - All other bits read 0; bits 0 and 2 are owned by the CSR file.
- Event pipeline: eventQ <= events every cycle.
  - Counter n increments by 1 at the end of cycle t+1 when its selector s ≠ 0, eventQ[s-1] = 1 and inhibit bit n = 0.
  - An event strobed in cycle t is visible on a read in cycle t+2.
- Selector or inhibit writes take effect from the next cycle's increment decision. An eventQ entry already registered is evaluated against the new setting.
- Write and increment to the same counter in the same cycle:
  - The write wins and the increment is dropped.
  - A write to the other half of that counter also suppresses the increment.
- Wrap-around:
  - All ones + 1 → 0.
  - overflowPulse[n-3] is high for exactly the cycle after the wrapping edge.
  - No pulse is raised when a write sets the counter to 0.
- Width rule: increments are modulo 2^COUNTER_WIDTH; no carry is lost between halves.
- Counters are fully independent; several counters may select the same event.

Decomposition:
- Shared package:
  - Add MCOUNTINHIBIT = 12'h320 to CSRs_.
  - Add constants HPM_FIRST_INDEX = 3, HPM_COUNTER_BASE = 12'hB00, HPM_COUNTERH_BASE = 12'hB80, HPM_EVENT_BASE = 12'h320.
- Sub-module hpm_counter_slice, instantiated NUM_COUNTERS times via generate. Each slice holds:
  - the counter
  - the selector register
  - increment, write-priority and overflow-pulse logic
- The top level keeps address decode, eventQ, inhibit and the read mux.

Test Plan:
- Reset, then read 0xB03, 0xB83, 0x323 and 0x320 → all 0, csrHit = 1. Read 0x7C0 → csrHit = 0.
- Write 0x323 = 2; pulse events[1] for 5 single cycles; read 0xB03 two cycles after the last pulse → 5. Writing 0x323 = 9 with NUM_EVENTS = 8 reads back 0.
- Write 0xB03 = 0xFFFFFFFF and 0xB83 = 0xFFFFFFFF; select an always-high event → one cycle later the counter is 0 and overflowPulse[0] = 1 for one cycle. With COUNTER_WIDTH = 40, 0xB83 reads 0x000000FF before the wrap.
- Set mcountinhibit = 0x8 with the event held high for 10 cycles → the counter is unchanged. Clear the inhibit → it resumes incrementing by 1 per cycle.
- In the same cycle as a qualified eventQ hit, write 0xB03 = 0x100 → reads 0x100, not 0x101. Write 0xB10 (index 16 > NUM_COUNTERS) → reads 0, csrHit = 1.
- Assert reset mid-count with a counter at 0x1234 → all registers 0 next cycle; an event strobed in the reset cycle is not counted.
